// File: rtl/jesd204b_tx_link_seq.sv
// -----------------------------------------------------------------------------
// jesd204b_tx_link_seq
//
// JESD204B transmit link-layer sequencer. Sits between the TX transport layer
// and the 8b/10b encoder and walks the link through its three phases:
//   CGS  : every octet is K28.5 while the receiver holds SYNC~ low.
//   ILAS : starts on the first LMFC pulse seen with SYNC~ released. Sends
//          ILAS_MULTIFRAMES multiframes of /R/ ... ramp ... /A/. Multiframe 1
//          also carries /Q/ and the 14 link-configuration octets.
//   DATA : passes the transport payload through, with no K characters.
// Whenever the synchronised SYNC~ is low in ILAS or DATA, the link drops back
// to CGS on the next edge.
//
// Optional feature (compile-time macro JESD_TX_RESYNC_CNT_EN):
//   Adds resync_cnt_o. This is a saturating 8-bit count of ILAS->CGS and
//   DATA->CGS transitions.
//
// Ports
//   clk_i         link clock, one beat per cycle
//   rst_ni        asynchronous active-low reset
//   sync_ni       SYNC~ from the receiver (asynchronous, active-low)
//   lmfc_clk_i    one-cycle pulse on beat 0 of every multiframe
//   ilas_cfg_i    14 config octets, octet n = [8n+7:8n], latched at ILAS start
//   data_i        transport payload, octet j = [8j+7:8j]
//   data_ready_o  high while in DATA; data_i is taken every cycle it is high
//   tx_data_o     octets to the encoder
//   tx_charisk_o  per-octet K flag
//   link_state_o  0 = CGS, 1 = ILAS, 2 = DATA
//   resync_cnt_o  (JESD_TX_RESYNC_CNT_EN only) count of resynchronisations
//
// Timing: link_state_o and data_ready_o reflect the current state. The octets
// for that state reach tx_data_o/tx_charisk_o one cycle later. So data_i sampled
// while data_ready_o is high appears on tx_data_o on the next cycle.
// -----------------------------------------------------------------------------
module jesd204b_tx_link_seq #(
  parameter int PARALLEL_OCTETS      = 4,
  parameter int BEATS_PER_MULTIFRAME = 16,
  parameter int ILAS_MULTIFRAMES     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sync_ni,
  input  logic                         lmfc_clk_i,
  input  logic [111:0]                 ilas_cfg_i,
  input  logic [8*PARALLEL_OCTETS-1:0] data_i,
`ifdef JESD_TX_RESYNC_CNT_EN
  output logic [7:0]                   resync_cnt_o,
`endif
  output logic                         data_ready_o,
  output logic [8*PARALLEL_OCTETS-1:0] tx_data_o,
  output logic [PARALLEL_OCTETS-1:0]   tx_charisk_o,
  output logic [1:0]                   link_state_o
);

  localparam int P      = PARALLEL_OCTETS;
  localparam int BEATS  = BEATS_PER_MULTIFRAME;
  localparam int NMF    = ILAS_MULTIFRAMES;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MW     = $clog2(NMF);
  // The octet index must be at least 8 bits wide because the D-char ramp
  // uses k[7:0].
  localparam int KW_RAW = $clog2(BEATS * P) + 1;
  localparam int KW     = (KW_RAW > 8) ? KW_RAW : 8;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [MW-1:0] MF_LAST   = MW'(NMF - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(BEATS * P - 1);

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // SYNC~ synchroniser. It resets to 0 (SYNC~ asserted), so the link always
  // starts in CGS.
  // ---------------------------------------------------------------------------
  logic sync_meta_q;
  logic sync_s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_meta_q <= 1'b0;
      sync_s_q    <= 1'b0;
    end else begin
      sync_meta_q <= sync_ni;
      sync_s_q    <= sync_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [MW-1:0]   mf_q, mf_d;
  logic [111:0]    cfg_q, cfg_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CGS;
      beat_q  <= '0;
      mf_q    <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mf_q    <= mf_d;
      cfg_q   <= cfg_d;
    end
  end

  logic last_beat;
  logic last_mf;
  assign last_beat = (beat_q == BEAT_LAST);
  assign last_mf   = (mf_q == MF_LAST);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    mf_d    = mf_q;
    cfg_d   = cfg_q;
    if (!sync_s_q) begin
      // A low SYNC~ wins over everything, including an LMFC pulse in CGS.
      state_d = ST_CGS;
      beat_d  = '0;
      mf_d    = '0;
    end else begin
      unique case (state_q)
        ST_CGS: begin
          if (lmfc_clk_i) begin
            state_d = ST_ILAS;
            beat_d  = '0;
            mf_d    = '0;
            cfg_d   = ilas_cfg_i;
          end
        end
        ST_ILAS: begin
          // The local beat counter is authoritative here. LMFC is not used,
          // so DATA begins exactly on a multiframe boundary.
          if (last_beat) begin
            beat_d = '0;
            if (last_mf) begin
              state_d = ST_DATA;
              mf_d    = '0;
            end else begin
              mf_d = mf_q + MW'(1);
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        ST_DATA: begin
          state_d = ST_DATA;
        end
        default: begin
          state_d = ST_CGS;
          beat_d  = '0;
          mf_d    = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ILAS octet generation, one lane slot per octet of the beat
  // ---------------------------------------------------------------------------
  logic [P-1:0][7:0] ilas_oct;
  logic [P-1:0]      ilas_k;
  logic [127:0]      cfg_ext;

  // Two zero octets pad the table so that any 4-bit index stays in range.
  assign cfg_ext = {16'h0000, cfg_q};

  for (genvar gi = 0; gi < P; gi++) begin : g_oct
    logic [KW-1:0] k;
    logic [3:0]    cfg_idx;
    logic [7:0]    oct_byte;
    logic          oct_k;

    assign k       = KW'(beat_q) * KW'(P) + KW'(gi);
    assign cfg_idx = k[3:0] - 4'd2;

    always_comb begin
      oct_byte = k[7:0];
      oct_k    = 1'b0;
      if (k == '0) begin
        oct_byte = 8'h1C;              // K28.0 /R/
        oct_k    = 1'b1;
      end else if (k == K_LAST) begin
        oct_byte = 8'h7C;              // K28.3 /A/
        oct_k    = 1'b1;
      end else if (mf_q == MW'(1) && k == KW'(1)) begin
        oct_byte = 8'h9C;              // K28.4 /Q/
        oct_k    = 1'b1;
      end else if (mf_q == MW'(1) && k <= KW'(15)) begin
        // k is 2..15 here, because 0 and 1 were handled above.
        oct_byte = cfg_ext[{cfg_idx, 3'b000} +: 8];
      end
    end

    assign ilas_oct[gi] = oct_byte;
    assign ilas_k[gi]   = oct_k;
  end

  // ---------------------------------------------------------------------------
  // Output decode and output registers
  // ---------------------------------------------------------------------------
  logic [8*P-1:0] tx_data_q, tx_data_d;
  logic [P-1:0]   tx_charisk_q, tx_charisk_d;
  logic           data_ready_q, data_ready_d;

  always_comb begin
    tx_data_d    = {P{8'hBC}};         // K28.5
    tx_charisk_d = '1;
    unique case (state_q)
      ST_ILAS: begin
        tx_data_d    = ilas_oct;
        tx_charisk_d = ilas_k;
      end
      ST_DATA: begin
        tx_data_d    = data_i;
        tx_charisk_d = '0;
      end
      default: begin
        tx_data_d    = {P{8'hBC}};
        tx_charisk_d = '1;
      end
    endcase
    // Ready follows the state register itself. It therefore drops in the
    // same update that leaves DATA.
    data_ready_d = (state_d == ST_DATA);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_data_q    <= {P{8'hBC}};
      tx_charisk_q <= '1;
      data_ready_q <= 1'b0;
    end else begin
      tx_data_q    <= tx_data_d;
      tx_charisk_q <= tx_charisk_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_charisk_o = tx_charisk_q;
  assign data_ready_o = data_ready_q;
  assign link_state_o = state_q;

`ifdef JESD_TX_RESYNC_CNT_EN
  logic [7:0] resync_cnt_q, resync_cnt_d;

  always_comb begin
    resync_cnt_d = resync_cnt_q;
    if (state_q != ST_CGS && state_d == ST_CGS && resync_cnt_q != 8'hFF) begin
      resync_cnt_d = resync_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resync_cnt_q <= 8'd0;
    end else begin
      resync_cnt_q <= resync_cnt_d;
    end
  end

  assign resync_cnt_o = resync_cnt_q;
`endif

endmodule

// File: tb/tb_jesd204b_tx_link_seq.sv
module tb_jesd204b_tx_link_seq;

  localparam int P          = 4;
  localparam int BEATS      = 16;
  localparam int NMF        = 4;
  localparam int ILAS_BEATS = NMF * BEATS;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          sync_ni;
  logic          lmfc_clk_i;
  logic [111:0]  ilas_cfg_i;
  logic [8*P-1:0] data_i;
  logic          data_ready_o;
  logic [8*P-1:0] tx_data_o;
  logic [P-1:0]  tx_charisk_o;
  logic [1:0]    link_state_o;
`ifdef JESD_TX_RESYNC_CNT_EN
  logic [7:0]    resync_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  jesd204b_tx_link_seq #(
    .PARALLEL_OCTETS(P),
    .BEATS_PER_MULTIFRAME(BEATS),
    .ILAS_MULTIFRAMES(NMF)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .sync_ni(sync_ni),
    .lmfc_clk_i(lmfc_clk_i),
    .ilas_cfg_i(ilas_cfg_i),
    .data_i(data_i),
`ifdef JESD_TX_RESYNC_CNT_EN
    .resync_cnt_o(resync_cnt_o),
`endif
    .data_ready_o(data_ready_o),
    .tx_data_o(tx_data_o),
    .tx_charisk_o(tx_charisk_o),
    .link_state_o(link_state_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The whole ILAS is treated as one flat octet stream
  // n = 0 .. NMF*BEATS*P-1. Each octet is derived from its multiframe number
  // and its position inside the multiframe.
  // ---------------------------------------------------------------------------
  function automatic logic [8*P+P-1:0] ilas_word(input int beat, input logic [111:0] cfg);
    logic [8*P-1:0] d;
    logic [P-1:0]   kf;
    int n, mf, o;
    d  = '0;
    kf = '0;
    for (int j = 0; j < P; j++) begin
      n  = beat * P + j;
      mf = n / (BEATS * P);
      o  = n % (BEATS * P);
      if (o == 0) begin
        d[8*j +: 8] = 8'h1C; kf[j] = 1'b1;
      end else if (o == BEATS * P - 1) begin
        d[8*j +: 8] = 8'h7C; kf[j] = 1'b1;
      end else if (mf == 1 && o == 1) begin
        d[8*j +: 8] = 8'h9C; kf[j] = 1'b1;
      end else if (mf == 1 && o >= 2 && o <= 15) begin
        d[8*j +: 8] = cfg[8*(o-2) +: 8];
      end else begin
        d[8*j +: 8] = 8'(o);
      end
    end
    return {kf, d};
  endfunction

  logic [1:0]     m_mode;
  int             m_beat;
  logic           ms1, ms2;
  logic [111:0]   m_cfg;
  logic [8*P-1:0] exp_data;
  logic [P-1:0]   exp_k;
  logic [7:0]     exp_resync;

  function automatic logic [1:0] next_mode(input logic [1:0] mode, input logic s,
                                           input logic lmfc, input int beat);
    if (!s) return 2'd0;
    if (mode == 2'd0) return lmfc ? 2'd1 : 2'd0;
    if (mode == 2'd1) return (beat == ILAS_BEATS - 1) ? 2'd2 : 2'd1;
    return 2'd2;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_mode     <= 2'd0;
      m_beat     <= 0;
      ms1        <= 1'b0;
      ms2        <= 1'b0;
      m_cfg      <= '0;
      exp_data   <= {P{8'hBC}};
      exp_k      <= '1;
      exp_resync <= 8'd0;
    end else begin
      if (m_mode == 2'd1) begin
        {exp_k, exp_data} <= ilas_word(m_beat, m_cfg);
      end else if (m_mode == 2'd2) begin
        exp_data <= data_i;
        exp_k    <= '0;
      end else begin
        exp_data <= {P{8'hBC}};
        exp_k    <= '1;
      end
      m_mode <= next_mode(m_mode, ms2, lmfc_clk_i, m_beat);
      if (!ms2) begin
        m_beat <= 0;
        if (m_mode != 2'd0 && exp_resync != 8'hFF) exp_resync <= exp_resync + 8'd1;
      end else if (m_mode == 2'd0 && lmfc_clk_i) begin
        m_beat <= 0;
        m_cfg  <= ilas_cfg_i;
      end else if (m_mode == 2'd1) begin
        m_beat <= (m_beat == ILAS_BEATS - 1) ? 0 : m_beat + 1;
      end
      ms1 <= sync_ni;
      ms2 <= ms1;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("link_state", 64'(link_state_o), 64'(m_mode));
      chk("data_ready", 64'(data_ready_o), 64'(m_mode == 2'd2));
      chk("tx_data",    64'(tx_data_o),    64'(exp_data));
      chk("tx_charisk", 64'(tx_charisk_o), 64'(exp_k));
`ifdef JESD_TX_RESYNC_CNT_EN
      chk("resync_cnt", 64'(resync_cnt_o), 64'(exp_resync));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int lmfc_phase;
  logic [111:0] cfg_ramp;
  logic [8*P-1:0] cap_d [ILAS_BEATS];
  logic [P-1:0]   cap_k [ILAS_BEATS];

  task automatic step();
    @(negedge clk_i);
    cyc++;
    lmfc_clk_i = ((cyc % BEATS) == lmfc_phase);
    data_i     = $urandom;
  endtask

  task automatic wait_state(input logic [1:0] st, input int limit, input string name);
    int n;
    n = 0;
    while (link_state_o != st && n < limit) begin
      step();
      n++;
    end
    if (link_state_o != st) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for link_state %0d, got %0d", name, st, link_state_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 14; i++) cfg_ramp[8*i +: 8] = 8'(i);
    lmfc_phase = $urandom_range(0, BEATS - 1);
    rst_ni     = 1'b0;
    sync_ni    = 1'b0;
    lmfc_clk_i = 1'b0;
    data_i     = '0;
    ilas_cfg_i = cfg_ramp;
    #1 cmp_en  = 1'b1;
    repeat (3) step();
    rst_ni = 1'b1;

    // CGS while SYNC~ is held low
    repeat (100) step();
    chk("cgs_data",   64'(tx_data_o),    64'h0000_0000_BCBC_BCBC);
    chk("cgs_charisk", 64'(tx_charisk_o), 64'hF);
    chk("cgs_state",  64'(link_state_o), 64'd0);
    chk("cgs_ready",  64'(data_ready_o), 64'd0);

    // Release SYNC~ and capture the whole ILAS
    sync_ni = 1'b1;
    wait_state(2'd1, 200, "ilas_start");
    for (int i = 0; i < ILAS_BEATS; i++) begin
      step();
      cap_d[i] = tx_data_o;
      cap_k[i] = tx_charisk_o;
    end
    chk("ilas_b0_data",  64'(cap_d[0]),  64'h0302_011C);
    chk("ilas_b0_k",     64'(cap_k[0]),  64'h1);
    chk("ilas_b15_data", 64'(cap_d[15]), 64'h7C3E_3D3C);
    chk("ilas_b15_k",    64'(cap_k[15]), 64'h8);
    chk("ilas_m1b0_data", 64'(cap_d[16]), 64'h0100_9C1C);
    chk("ilas_m1b0_k",   64'(cap_k[16]), 64'h3);
    chk("ilas_b63_data", 64'(cap_d[63]), 64'h7C3E_3D3C);
    chk("data_state",    64'(link_state_o), 64'd2);
    chk("data_ready",    64'(data_ready_o), 64'd1);
    data_i = 32'hDEAD_BEEF;
    step();
    chk("data_pass",     64'(tx_data_o),    64'hDEAD_BEEF);
    chk("data_charisk",  64'(tx_charisk_o), 64'h0);

    // Pull SYNC~ low for 3 cycles during DATA
    repeat (10) step();
    sync_ni = 1'b0;
    step();
    step();
    chk("resync_still_data", 64'(link_state_o), 64'd2);
    step();
    chk("resync_cgs", 64'(link_state_o), 64'd0);
    chk("resync_ready", 64'(data_ready_o), 64'd0);
    sync_ni = 1'b1;
`ifdef JESD_TX_RESYNC_CNT_EN
    chk("resync_cnt_one", 64'(resync_cnt_o), 64'd1);
`endif

    // Realign with a random configuration
    ilas_cfg_i = {$urandom, $urandom, $urandom, 16'($urandom)};
    wait_state(2'd1, 200, "realign_ilas");
    wait_state(2'd2, 200, "realign_data");

    // Random SYNC~ drops and random configuration changes
    for (int i = 0; i < 1500; i++) begin
      step();
      if (sync_ni && $urandom_range(0, 149) == 0) begin
        sync_ni = 1'b0;
        repeat ($urandom_range(1, 12)) step();
        sync_ni = 1'b1;
      end
      if ($urandom_range(0, 63) == 0)
        ilas_cfg_i = {$urandom, $urandom, $urandom, 16'($urandom)};
    end

    // Asynchronous reset at multiframe 2, beat 7
    ilas_cfg_i = cfg_ramp;
    sync_ni = 1'b0;
    repeat (5) step();
    sync_ni = 1'b1;
    wait_state(2'd1, 200, "pre_reset_ilas");
    repeat (2 * BEATS + 7) step();
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_data",  64'(tx_data_o),    64'h0000_0000_BCBC_BCBC);
    chk("async_rst_k",     64'(tx_charisk_o), 64'hF);
    chk("async_rst_state", 64'(link_state_o), 64'd0);
    chk("async_rst_ready", 64'(data_ready_o), 64'd0);
    step();
    rst_ni = 1'b1;
    wait_state(2'd1, 200, "post_reset_ilas");
    step();
    chk("restart_b0_data", 64'(tx_data_o),    64'h0302_011C);
    chk("restart_b0_k",    64'(tx_charisk_o), 64'h1);
    repeat (BEATS) step();
    chk("restart_m1b0_data", 64'(tx_data_o), 64'h0100_9C1C);
    repeat (80) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
